op_acc_stream: RTL and testbench

Streaming IEEE-754 single-precision accumulator, the stage directly downstream of `op_sum`. It instantiates one `op_sum` and feeds that adder's result back into a running-sum register. It reduces a packet of `VSIZE`-bit float samples (for example, per-beam gradient/Hessian terms in the scan matcher) to one sum. Input and output use valid/ready handshakes. The block sustains one sample per clock.

---
 rtl/op_acc_stream.sv | 240 ++++++++++++++++++++++++
 tb/tb_op_acc_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/op_acc_stream.sv
// op_acc_stream: streaming float32 packet accumulator.
// Each packet of samples is reduced to one sum, added strictly in arrival order.
// op_sum: a combinational float32 adder. It rounds to nearest-even, keeps
// denormals, returns the canonical quiet NaN 32'h7FC00000 and overflows to Inf.
// Optional feature: define OP_ACC_COUNT_EN to add the CNT_W parameter and the
// saturating out_count sample counter.

module op_sum #(
  parameter int VSIZE = 32
) (
  input  logic [VSIZE-1:0] a_i,
  input  logic [VSIZE-1:0] b_i,
  output logic [VSIZE-1:0] sum_o
);

  // Leading-zero count of the 27-bit extended mantissa (27 when all zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap;
  logic        sl, ss;
  logic [7:0]  el_f, es_f;
  logic [22:0] fl, fs;
  logic [7:0]  el, es;
  logic [23:0] ml, ms;
  logic [7:0]  d;
  logic [4:0]  dc;
  logic [53:0] sh;
  logic [26:0] ms_al, ml_x;
  logic        eff_sub;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [7:0]  shamt;
  logic [26:0] m;
  logic [9:0]  e;
  logic        g, rs, rup;
  logic [24:0] mr;
  logic [9:0]  e_fin;
  logic [22:0] frac_fin;

  // Align, add/subtract, normalise, round to nearest-even, then patch specials.
  always_comb begin
    a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);

    // L always holds the larger magnitude so the subtraction never goes negative.
    swap = b_i[30:0] > a_i[30:0];
    {sl, el_f, fl} = swap ? b_i : a_i;
    {ss, es_f, fs} = swap ? a_i : b_i;

    el = (el_f == 8'd0) ? 8'd1 : el_f;
    es = (es_f == 8'd0) ? 8'd1 : es_f;
    ml = {el_f != 8'd0, fl};
    ms = {es_f != 8'd0, fs};

    // Shifting by 31 already pushes every bit of ms below the sticky bit.
    d     = el - es;
    dc    = (d > 8'd31) ? 5'd31 : d[4:0];
    sh    = {ms, 30'd0} >> dc;
    ms_al = {sh[53:28], sh[27] | (|sh[26:0])};
    ml_x  = {ml, 3'b000};

    eff_sub = sl ^ ss;
    sum = eff_sub ? ({1'b0, ml_x} - {1'b0, ms_al}) : ({1'b0, ml_x} + {1'b0, ms_al});
    lz  = lzc27(sum[26:0]);

    shamt = 8'd0;
    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = {2'b00, el} + 10'd1;
    end else begin
      // The left shift stops at exponent 1, which leaves a denormal result.
      if ({3'b000, lz} < (el - 8'd1)) shamt = {3'b000, lz};
      else                            shamt = el - 8'd1;
      m = sum[26:0] << shamt;
      e = {2'b00, el} - {2'b00, shamt};
    end

    g   = m[2];
    rs  = m[1] | m[0];
    rup = g & (rs | m[3]);
    mr  = {1'b0, m[26:3]} + {24'd0, rup};

    if (mr[24]) begin
      e_fin    = e + 10'd1;
      frac_fin = 23'd0;
    end else if (mr[23]) begin
      e_fin    = e;
      frac_fin = mr[22:0];
    end else begin
      e_fin    = 10'd0;
      frac_fin = mr[22:0];
    end

    if (e_fin >= 10'd255) sum_o = {sl, 8'hFF, 23'd0};
    else                  sum_o = {sl, e_fin[7:0], frac_fin};

    // An exact zero is +0, except when both inputs are -0.
    if (sum == 28'd0) sum_o = {(eff_sub ? 1'b0 : sl), 31'd0};

    if (a_nan || b_nan)                          sum_o = 32'h7FC0_0000;
    else if (a_inf && b_inf && (a_i[31] != b_i[31])) sum_o = 32'h7FC0_0000;
    else if (a_inf)                              sum_o = a_i;
    else if (b_inf)                              sum_o = b_i;
  end

endmodule

module op_acc_stream #(
  parameter int VSIZE = 32
`ifdef OP_ACC_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VSIZE-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [VSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OP_ACC_COUNT_EN
  , output logic [CNT_W-1:0] out_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [VSIZE-1:0] acc_q;
  logic [VSIZE-1:0] acc_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_accept;

  assign in_accept = in_valid && in_ready_q;

  op_sum #(.VSIZE(VSIZE)) u_sum (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (acc_d)
  );

`ifdef OP_ACC_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The sample counter saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count samples: the first beat loads 1 and every later accepted beat adds 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (in_accept) begin
      cnt_q <= (state_q == ST_IDLE) ? CNT_W'(1) : cnt_d;
    end
  end

  assign out_count = cnt_q;
`endif

  // Packet FSM. The handshake outputs are registered alongside the state so
  // that out_ready has no combinational path to in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_accept) begin
            // The first beat bypasses the adder so specials pass through bit-exact.
            acc_q <= in_data;
            if (in_last) begin
              state_q     <= ST_OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (in_accept) begin
            acc_q <= acc_d;
            if (in_last) begin
              state_q     <= ST_OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          // acc is left as it is; the next packet's first beat overwrites it.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_op_acc_stream.sv
// Directed testbench for op_acc_stream. Count checks compile only with OP_ACC_COUNT_EN.
module tb_op_acc_stream;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef OP_ACC_COUNT_EN
  logic [1:0]  out_count;
`endif

  int tests = 0;
  int fails = 0;

  op_acc_stream #(
    .VSIZE(32)
`ifdef OP_ACC_COUNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef OP_ACC_COUNT_EN
    , .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    send(a, 1'b0);
    send(b, 1'b1);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, out_data, exp);
    take();
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 32'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'h0000_0000);
`ifdef OP_ACC_COUNT_EN
    check("rst_out_count", {30'd0, out_count}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // in_last without in_valid does nothing
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    check("last_no_valid", {31'd0, out_valid}, 32'd0);

    // 1.5 + 2.25 + 0.25 = 4.0, output one cycle after the last beat
    send(32'h3FC0_0000, 1'b0);
    check("p1_mid_valid", {31'd0, out_valid}, 32'd0);
    send(32'h4010_0000, 1'b0);
    check("p1_partial", out_data, 32'h4070_0000);
    send(32'h3E80_0000, 1'b1);
    check("p1_valid", {31'd0, out_valid}, 32'd1);
    check("p1_in_ready", {31'd0, in_ready}, 32'd0);
    check("p1_data", out_data, 32'h4080_0000);
`ifdef OP_ACC_COUNT_EN
    check("p1_count", {30'd0, out_count}, 32'd3);
`endif
    take();
    check("p1_done_valid", {31'd0, out_valid}, 32'd0);
    check("p1_done_ready", {31'd0, in_ready}, 32'd1);

    // single-beat -0.0 passes through bit-exact
    send(32'h8000_0000, 1'b1);
    check("negzero_valid", {31'd0, out_valid}, 32'd1);
    check("negzero_data", out_data, 32'h8000_0000);
`ifdef OP_ACC_COUNT_EN
    check("negzero_count", {30'd0, out_count}, 32'd1);
`endif
    take();

    // single-beat NaN payload is not canonicalised
    send(32'h7FC0_0001, 1'b1);
    check("nan_pass", out_data, 32'h7FC0_0001);
    take();

    // back-pressure: 1.0 + 2.0 held with out_ready low, inputs ignored meanwhile
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h4120_0000;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_data", out_data, 32'h4040_0000);
      tick();
    end
    in_valid = 1'b0;
    take();
    check("hold_rel_valid", {31'd0, out_valid}, 32'd0);
    check("hold_rel_ready", {31'd0, in_ready}, 32'd1);

    // gapped input: acc holds across idle cycles
    send(32'h3F80_0000, 1'b0);
    tick();
    tick();
    check("gap_hold1", out_data, 32'h3F80_0000);
    send(32'h3F80_0000, 1'b0);
    tick();
    check("gap_hold2", out_data, 32'h4000_0000);
    check("gap_no_valid", {31'd0, out_valid}, 32'd0);
    send(32'h3F80_0000, 1'b1);
    check("gap_valid", {31'd0, out_valid}, 32'd1);
    check("gap_data", out_data, 32'h4040_0000);
    take();

    // adder corner cases
    pair("cancel_pos_zero", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    pair("rne_tie_even",    32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    pair("rne_above_half",  32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001);
    pair("overflow_inf",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    pair("inf_minus_inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    pair("denormal_add",    32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
    pair("cancel_small",    32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000);
    pair("neg_zero_pair",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    pair("mixed_sign",      32'h4120_0000, 32'hC040_0000, 32'h40E0_0000);

    // reset mid-packet discards the partial sum
    send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b0);
    check("abort_partial", out_data, 32'h4000_0000);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_data", out_data, 32'h0000_0000);
    tick();
    rst = 1'b0;
    tick();
    check("abort_no_output", {31'd0, out_valid}, 32'd0);
    send(32'h40A0_0000, 1'b1);
    check("abort_next_valid", {31'd0, out_valid}, 32'd1);
    check("abort_next_data", out_data, 32'h40A0_0000);
`ifdef OP_ACC_COUNT_EN
    check("abort_next_count", {30'd0, out_count}, 32'd1);
`endif
    take();

    // five beats of 1.0; a 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b1);
    check("five_valid", {31'd0, out_valid}, 32'd1);
    check("five_data", out_data, 32'h40A0_0000);
`ifdef OP_ACC_COUNT_EN
    check("five_count_sat", {30'd0, out_count}, 32'd3);
`endif
    take();
    check("five_done_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
